// File: rtl/mem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl_pkg
// Purpose  : Shared MEM-stage types: load/store kind, access FSM states,
//            dbus size codes and request/response structs.
// Revision : 1.0 - initial release
// ============================================================================
package mem_access_ctrl_pkg;

    typedef enum logic [2:0] {
        LS_NONE    = 3'd0,
        LS_BTYE    = 3'd1,
        LS_BTYE_U  = 3'd2,
        LS_HALFW   = 3'd3,
        LS_HALFW_U = 3'd4,
        LS_WORD    = 3'd5
    } ls_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mem_state_t;

    localparam logic [1:0] MSIZE_1 = 2'd0;
    localparam logic [1:0] MSIZE_2 = 2'd1;
    localparam logic [1:0] MSIZE_4 = 2'd2;

    typedef struct packed {
        logic        valid;
        logic [1:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

    function automatic logic is_misaligned(input ls_t ls, input logic [1:0] lo);
        case (ls)
            LS_HALFW, LS_HALFW_U: return lo[0];
            LS_WORD:              return lo != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_data_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_data_align
// Purpose  : Combinational store lane/strobe generation and load byte/half
//            extraction with sign or zero extension.
// Revision : 1.0 - initial release
// ============================================================================
module mem_data_align
    import mem_access_ctrl_pkg::*;
(
    input  ls_t         st_ls,
    input  logic        st_we,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] wdata,
    output logic [1:0]  st_size,
    output logic [3:0]  st_strobe,
    output logic [31:0] st_data,
    input  ls_t         ld_ls,
    input  logic        ld_we,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        st_size   = MSIZE_4;
        st_strobe = 4'b1111;
        st_data   = wdata;
        case (st_ls)
            LS_BTYE, LS_BTYE_U: begin
                st_size   = MSIZE_1;
                st_strobe = 4'b0001 << st_addr_lo;
                st_data   = {4{wdata[7:0]}};
            end
            LS_HALFW, LS_HALFW_U: begin
                st_size   = MSIZE_2;
                st_strobe = 4'b0011 << st_addr_lo;
                st_data   = {2{wdata[15:0]}};
            end
            default: ;
        endcase
        if (!st_we) st_strobe = 4'b0000;
    end

    // Halfword addresses reaching here are always even, so lo[1] picks the lane.
    always_comb begin
        case (ld_addr_lo)
            2'd0:    w_byte = ld_raw[7:0];
            2'd1:    w_byte = ld_raw[15:8];
            2'd2:    w_byte = ld_raw[23:16];
            default: w_byte = ld_raw[31:24];
        endcase
        w_half = ld_addr_lo[1] ? ld_raw[31:16] : ld_raw[15:0];
    end

    always_comb begin
        case (ld_ls)
            LS_BTYE:    ld_data = {{24{w_byte[7]}}, w_byte};
            LS_BTYE_U:  ld_data = {24'd0, w_byte};
            LS_HALFW:   ld_data = {{16{w_half[15]}}, w_half};
            LS_HALFW_U: ld_data = {16'd0, w_half};
            default:    ld_data = ld_raw;
        endcase
        if (ld_we) ld_data = 32'd0;
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : MEM-stage data-bus sequencer: one access per instruction with
//            pipeline stall and extended load data. Optional macro
//            MEM_ALIGN_CHECK_EN traps misaligned accesses instead of issuing.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    input  ls_t                   ls_flag,
    input  logic                  mem_write_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic                  stall,
    output logic                  done,
    output logic [31:0]           rdata,
    output logic                  addr_err,
    output logic                  dreq_valid,
    output logic [ADDR_WIDTH-1:0] dreq_addr,
    output logic [1:0]            dreq_size,
    output logic [3:0]            dreq_strobe,
    output logic [31:0]           dreq_data,
    input  logic                  dresp_addr_ok,
    input  logic                  dresp_data_ok,
    input  logic [31:0]           dresp_data
);

    mem_state_t            r_state;
    ls_t                   r_ls;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    dbus_req_t             r_req;
    logic                  r_done;
    logic [31:0]           r_rdata;

    dbus_resp_t            w_resp;
    logic                  w_mem_op;
    logic                  w_misaligned;
    logic [ADDR_WIDTH-1:0] w_issue_addr;
    logic [1:0]            w_st_size;
    logic [3:0]            w_st_strobe;
    logic [31:0]           w_st_data;
    logic [31:0]           w_ld_data;

    assign w_resp   = '{addr_ok: dresp_addr_ok, data_ok: dresp_data_ok, data: dresp_data};
    assign w_mem_op = req_valid && (ls_flag != LS_NONE);

`ifdef MEM_ALIGN_CHECK_EN
    logic r_addr_err;
    assign w_misaligned = is_misaligned(ls_flag, addr[1:0]);
    assign w_issue_addr = addr;
    assign addr_err     = r_addr_err;
`else
    logic w_word;
    logic w_half;
    assign w_word       = (ls_flag == LS_WORD);
    assign w_half       = (ls_flag == LS_HALFW) || (ls_flag == LS_HALFW_U);
    assign w_misaligned = 1'b0;
    // Without trapping, misaligned accesses are silently rounded down.
    assign w_issue_addr = {addr[ADDR_WIDTH-1:2], addr[1] & ~w_word, addr[0] & ~(w_word | w_half)};
    assign addr_err     = 1'b0;
`endif

    mem_data_align u_align (
        .st_ls      (ls_flag),
        .st_we      (mem_write_en),
        .st_addr_lo (w_issue_addr[1:0]),
        .wdata      (wdata),
        .st_size    (w_st_size),
        .st_strobe  (w_st_strobe),
        .st_data    (w_st_data),
        .ld_ls      (r_ls),
        .ld_we      (r_we),
        .ld_addr_lo (r_addr[1:0]),
        .ld_raw     (w_resp.data),
        .ld_data    (w_ld_data)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_ls       <= LS_NONE;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_req      <= '0;
            r_done     <= 1'b0;
            r_rdata    <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            r_addr_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_mem_op) begin
                        r_ls   <= ls_flag;
                        r_we   <= mem_write_en;
                        r_addr <= w_issue_addr;
                        if (w_misaligned) begin
                            r_state    <= ST_DONE;
                            r_done     <= 1'b1;
                            r_rdata    <= '0;
`ifdef MEM_ALIGN_CHECK_EN
                            r_addr_err <= 1'b1;
`endif
                        end else begin
                            r_state      <= ST_REQ;
                            r_req.valid  <= 1'b1;
                            r_req.size   <= w_st_size;
                            r_req.strobe <= w_st_strobe;
                            r_req.data   <= w_st_data;
                        end
                    end
                end
                // data_ok without addr_ok is a slave protocol violation and is ignored here.
                ST_REQ: begin
                    if (w_resp.addr_ok) begin
                        r_req.valid <= 1'b0;
                        if (w_resp.data_ok) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_rdata <= w_ld_data;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (w_resp.data_ok) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_rdata <= w_ld_data;
                    end
                end
                ST_DONE: begin
                    r_state    <= ST_IDLE;
                    r_done     <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
                    r_addr_err <= 1'b0;
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign stall       = ((r_state == ST_IDLE) && w_mem_op) || (r_state == ST_REQ) || (r_state == ST_WAIT);
    assign done        = r_done;
    assign rdata       = r_rdata;
    assign dreq_valid  = r_req.valid;
    assign dreq_addr   = r_addr;
    assign dreq_size   = r_req.size;
    assign dreq_strobe = r_req.strobe;
    assign dreq_data   = r_req.data;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Directed self-checking bench for mem_access_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    ls_t         ls_flag;
    logic        mem_write_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        addr_err;
    logic        dreq_valid;
    logic [31:0] dreq_addr;
    logic [1:0]  dreq_size;
    logic [3:0]  dreq_strobe;
    logic [31:0] dreq_data;
    logic        dresp_addr_ok;
    logic        dresp_data_ok;
    logic [31:0] dresp_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_WIDTH(32)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .req_valid     (req_valid),
        .ls_flag       (ls_flag),
        .mem_write_en  (mem_write_en),
        .addr          (addr),
        .wdata         (wdata),
        .stall         (stall),
        .done          (done),
        .rdata         (rdata),
        .addr_err      (addr_err),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_addr_ok (dresp_addr_ok),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data)
    );

    always @(negedge clk)
        if (resetn)
            assert (!(dreq_valid && dresp_data_ok && !dresp_addr_ok))
            else $error("FAIL protocol: data_ok asserted before addr_ok");

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input ls_t ls, input logic we, input logic [31:0] a, input logic [31:0] wd);
        req_valid    = 1'b1;
        ls_flag      = ls;
        mem_write_en = we;
        addr         = a;
        wdata        = wd;
        #1;
    endtask

    task automatic respond(input logic aok, input logic dok, input logic [31:0] d);
        dresp_addr_ok = aok;
        dresp_data_ok = dok;
        dresp_data    = d;
    endtask

    task automatic test_reset();
        tests++; if (stall !== 1'b0)       begin fails++; $display("FAIL reset_stall: got %b want 0", stall); end
        tests++; if (done !== 1'b0)        begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        tests++; if (dreq_valid !== 1'b0)  begin fails++; $display("FAIL reset_dreq_valid: got %b want 0", dreq_valid); end
        tests++; if (rdata !== 32'd0)      begin fails++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        tests++; if ({dreq_addr, dreq_size, dreq_strobe, dreq_data} !== 70'd0)
                     begin fails++; $display("FAIL reset_dreq_fields: got %h %h %h %h want 0", dreq_addr, dreq_size, dreq_strobe, dreq_data); end
        tests++; if (addr_err !== 1'b0)    begin fails++; $display("FAIL reset_addr_err: got %b want 0", addr_err); end
    endtask

    task automatic test_sw();
        start(LS_WORD, 1'b1, 32'h100, 32'hDEADBEEF);
        tests++; if (stall !== 1'b1)       begin fails++; $display("FAIL sw_c0_stall: got %b want 1", stall); end
        tests++; if (dreq_valid !== 1'b0)  begin fails++; $display("FAIL sw_c0_valid: got %b want 0", dreq_valid); end
        tick();
        req_valid = 1'b0;
        respond(1'b1, 1'b1, 32'h0);
        tests++; if (dreq_valid !== 1'b1)  begin fails++; $display("FAIL sw_c1_valid: got %b want 1", dreq_valid); end
        tests++; if (dreq_addr !== 32'h100) begin fails++; $display("FAIL sw_addr: got %h want 00000100", dreq_addr); end
        tests++; if (dreq_strobe !== 4'hF) begin fails++; $display("FAIL sw_strobe: got %h want f", dreq_strobe); end
        tests++; if (dreq_data !== 32'hDEADBEEF) begin fails++; $display("FAIL sw_data: got %h want deadbeef", dreq_data); end
        tests++; if (dreq_size !== 2'd2)   begin fails++; $display("FAIL sw_size: got %0d want 2", dreq_size); end
        tests++; if (stall !== 1'b1)       begin fails++; $display("FAIL sw_c1_stall: got %b want 1", stall); end
        tick();
        respond(1'b0, 1'b0, 32'h0);
        tests++; if (done !== 1'b1)        begin fails++; $display("FAIL sw_c2_done: got %b want 1", done); end
        tests++; if (stall !== 1'b0)       begin fails++; $display("FAIL sw_c2_stall: got %b want 0", stall); end
        tests++; if (rdata !== 32'd0)      begin fails++; $display("FAIL sw_rdata: got %h want 0", rdata); end
        tests++; if (dreq_valid !== 1'b0)  begin fails++; $display("FAIL sw_c2_valid: got %b want 0", dreq_valid); end
        tick();
        tests++; if (done !== 1'b0)        begin fails++; $display("FAIL sw_c3_done: got %b want 0", done); end
    endtask

    task automatic test_lb_wait();
        start(LS_BTYE, 1'b0, 32'h103, 32'h0);
        tick();
        req_valid = 1'b0;
        respond(1'b1, 1'b0, 32'h0);
        tests++; if (dreq_strobe !== 4'h0 || dreq_size !== 2'd0 || dreq_addr !== 32'h103)
                     begin fails++; $display("FAIL lb_req: got strobe %h size %0d addr %h want 0 0 00000103", dreq_strobe, dreq_size, dreq_addr); end
        for (int c = 2; c <= 4; c++) begin
            tick();
            if (c == 2) respond(1'b0, 1'b0, 32'h0);
            if (c == 4) respond(1'b0, 1'b1, 32'h80112233);
            tests++; if (stall !== 1'b1 || done !== 1'b0 || dreq_valid !== 1'b0)
                         begin fails++; $display("FAIL lb_wait_c%0d: got stall %b done %b valid %b want 1 0 0", c, stall, done, dreq_valid); end
        end
        tick();
        respond(1'b0, 1'b0, 32'h0);
        tests++; if (done !== 1'b1 || stall !== 1'b0) begin fails++; $display("FAIL lb_c5_done: got done %b stall %b want 1 0", done, stall); end
        tests++; if (rdata !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_rdata: got %h want ffffff80", rdata); end
        tick();
    endtask

    task automatic test_half();
        ls_t         ls;
        logic [31:0] exp;
        for (int i = 0; i < 2; i++) begin
            ls  = (i == 0) ? LS_HALFW_U : LS_HALFW;
            exp = (i == 0) ? 32'h00008001 : 32'hFFFF8001;
            start(ls, 1'b0, 32'h102, 32'h0);
            tick();
            req_valid = 1'b0;
            respond(1'b1, 1'b1, 32'h8001FFFF);
            tests++; if (dreq_size !== 2'd1 || dreq_addr !== 32'h102)
                         begin fails++; $display("FAIL half%0d_req: got size %0d addr %h want 1 00000102", i, dreq_size, dreq_addr); end
            tick();
            respond(1'b0, 1'b0, 32'h0);
            tests++; if (done !== 1'b1 || rdata !== exp)
                         begin fails++; $display("FAIL half%0d_rdata: got done %b rdata %h want 1 %h", i, done, rdata, exp); end
            tick();
        end
    endtask

    task automatic test_sb_back_to_back();
        start(LS_BTYE, 1'b1, 32'h201, 32'h000000AB);
        tick();
        req_valid = 1'b0;
        respond(1'b1, 1'b1, 32'h0);
        tests++; if (dreq_strobe !== 4'b0010) begin fails++; $display("FAIL sb_strobe: got %b want 0010", dreq_strobe); end
        tests++; if (dreq_data !== 32'hABABABAB) begin fails++; $display("FAIL sb_data: got %h want abababab", dreq_data); end
        tests++; if (dreq_size !== 2'd0)   begin fails++; $display("FAIL sb_size: got %0d want 0", dreq_size); end
        tick();
        respond(1'b0, 1'b0, 32'h0);
        start(LS_WORD, 1'b0, 32'h200, 32'h0);
        tests++; if (done !== 1'b1 || stall !== 1'b0)
                     begin fails++; $display("FAIL b2b_done_cycle: got done %b stall %b want 1 0", done, stall); end
        tick();
        tests++; if (dreq_valid !== 1'b0 || stall !== 1'b1)
                     begin fails++; $display("FAIL b2b_idle_cycle: got valid %b stall %b want 0 1", dreq_valid, stall); end
        tick();
        req_valid = 1'b0;
        respond(1'b1, 1'b1, 32'h11223344);
        tests++; if (dreq_valid !== 1'b1 || dreq_addr !== 32'h200 || dreq_strobe !== 4'h0)
                     begin fails++; $display("FAIL b2b_req: got valid %b addr %h strobe %h want 1 00000200 0", dreq_valid, dreq_addr, dreq_strobe); end
        tick();
        respond(1'b0, 1'b0, 32'h0);
        tests++; if (done !== 1'b1 || rdata !== 32'h11223344)
                     begin fails++; $display("FAIL b2b_rdata: got done %b rdata %h want 1 11223344", done, rdata); end
        tick();
    endtask

    task automatic test_misaligned_word();
        start(LS_WORD, 1'b0, 32'h102, 32'h0);
        tick();
        req_valid = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        tests++; if (dreq_valid !== 1'b0)  begin fails++; $display("FAIL mis_valid: got %b want 0", dreq_valid); end
        tests++; if (addr_err !== 1'b1 || done !== 1'b1 || stall !== 1'b0 || rdata !== 32'd0)
                     begin fails++; $display("FAIL mis_c1: got err %b done %b stall %b rdata %h want 1 1 0 0", addr_err, done, stall, rdata); end
        tick();
        tests++; if (addr_err !== 1'b0 || done !== 1'b0)
                     begin fails++; $display("FAIL mis_c2: got err %b done %b want 0 0", addr_err, done); end
`else
        respond(1'b1, 1'b1, 32'hCAFEF00D);
        tests++; if (dreq_valid !== 1'b1 || dreq_addr !== 32'h100 || addr_err !== 1'b0)
                     begin fails++; $display("FAIL mis_req: got valid %b addr %h err %b want 1 00000100 0", dreq_valid, dreq_addr, addr_err); end
        tick();
        respond(1'b0, 1'b0, 32'h0);
        tests++; if (done !== 1'b1 || rdata !== 32'hCAFEF00D)
                     begin fails++; $display("FAIL mis_rdata: got done %b rdata %h want 1 cafef00d", done, rdata); end
        tick();
`endif
    endtask

    task automatic test_reset_mid_access();
        start(LS_WORD, 1'b1, 32'h300, 32'h55);
        tick();
        req_valid = 1'b0;
        respond(1'b1, 1'b0, 32'h0);
        tick();
        respond(1'b0, 1'b0, 32'h0);
        tests++; if (stall !== 1'b1)       begin fails++; $display("FAIL rst_mid_wait_stall: got %b want 1", stall); end
        #1 resetn = 1'b0;
        #1;
        tests++; if (stall !== 1'b0 || dreq_valid !== 1'b0 || dreq_addr !== 32'd0)
                     begin fails++; $display("FAIL rst_mid_outputs: got stall %b valid %b addr %h want 0 0 0", stall, dreq_valid, dreq_addr); end
        tick();
        resetn = 1'b1;
        tick();
        start(LS_WORD, 1'b1, 32'h104, 32'h12345678);
        tick();
        req_valid = 1'b0;
        respond(1'b1, 1'b1, 32'h0);
        tests++; if (dreq_valid !== 1'b1 || dreq_addr !== 32'h104 || dreq_strobe !== 4'hF || dreq_data !== 32'h12345678)
                     begin fails++; $display("FAIL rst_after_req: got valid %b addr %h strobe %h data %h want 1 00000104 f 12345678", dreq_valid, dreq_addr, dreq_strobe, dreq_data); end
        tick();
        respond(1'b0, 1'b0, 32'h0);
        tests++; if (done !== 1'b1)        begin fails++; $display("FAIL rst_after_done: got %b want 1", done); end
        tick();
    endtask

    initial begin
        resetn       = 1'b0;
        req_valid    = 1'b0;
        ls_flag      = LS_NONE;
        mem_write_en = 1'b0;
        addr         = 32'd0;
        wdata        = 32'd0;
        respond(1'b0, 1'b0, 32'h0);
        tick();
        tick();
        test_reset();
        resetn = 1'b1;
        tick();
        test_sw();
        test_lb_wait();
        test_half();
        test_sb_back_to_back();
        test_misaligned_word();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
